// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: machine word and PC-update operation encoding.
package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;

  // PC update selector driven by control
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JAL  = 2'b10,
    PC_JALR = 2'b11
  } pc_op_t;

  localparam rv32i_word PC_WORD_MASK = 32'hFFFF_FFFC;
  localparam rv32i_word JALR_MASK    = 32'hFFFF_FFFE;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC target computation for sequential, branch, JAL and JALR updates.
module pc_next_calc
  import rv32i_types::*;
(
  input  pc_op_t    upd_op,
  input  rv32i_word pc,
  input  rv32i_word imm,
  input  rv32i_word rs1_o,
  input  logic      br_en,
  output rv32i_word next_pc,
  output logic      misaligned
);

  rv32i_word pc_seq;
  rv32i_word pc_rel;
  rv32i_word jalr_sum;

  assign pc_seq   = pc + 32'd4;
  assign pc_rel   = pc + imm;
  assign jalr_sum = rs1_o + imm;

  // Select raw target; wraps mod 2^32 by construction
  always_comb begin
    next_pc = pc_seq;
    case (upd_op)
      PC_SEQ:  next_pc = pc_seq;
      PC_BR:   next_pc = br_en ? pc_rel : pc_seq;
      PC_JAL:  next_pc = pc_rel;
      PC_JALR: next_pc = jalr_sum & JALR_MASK;
      default: next_pc = pc_seq;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM for the multicycle RV32I core.
// Optional branch statistics counters enabled by defining BRANCH_STATS_EN.
module pc_fetch_unit
  import rv32i_types::*;
#(
  parameter rv32i_word   RESET_PC = 32'h0000_0060,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_word         mem_rdata,
  input  logic              mem_resp,
  output logic              mem_read,
  output rv32i_word         mem_address,
  output rv32i_word         instr,
  output logic              instr_valid,
  input  logic              upd_valid,
  input  pc_op_t            upd_op,
  input  logic              br_en,
  input  rv32i_word         imm,
  input  rv32i_word         rs1_o,
  output rv32i_word         pc,
  output rv32i_word         pc_plus4,
  output logic              misalign,
  output logic [STAT_W-1:0] br_taken_cnt,
  output logic [STAT_W-1:0] br_nt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10
  } state_e;

  state_e    state_q, state_d;
  rv32i_word pc_q, pc_d;
  rv32i_word instr_q, instr_d;
  logic      misalign_q, misalign_d;
  rv32i_word next_pc;
  logic      next_misaligned;

  pc_next_calc u_next (
    .upd_op     (upd_op),
    .pc         (pc_q),
    .imm        (imm),
    .rs1_o      (rs1_o),
    .br_en      (br_en),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  // State, PC, instruction latch and sticky misalign flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    misalign_d  = misalign_q;
    mem_read    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          instr_d = mem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (upd_valid) begin
          pc_d       = next_pc & PC_WORD_MASK;
          misalign_d = misalign_q | next_misaligned;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc          = pc_q;
  assign mem_address = pc_q;
  assign instr       = instr_q;
  assign misalign    = misalign_q;
  assign pc_plus4    = pc_q + 32'd4;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_q;
  logic [STAT_W-1:0] nt_q;
  logic              br_fire;

  assign br_fire = (state_q == S_ISSUE) && upd_valid && (upd_op == PC_BR);

  // Saturating taken / not-taken counters for accepted conditional branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q <= '0;
      nt_q    <= '0;
    end else if (br_fire) begin
      if (br_en && !(&taken_q)) begin
        taken_q <= taken_q + STAT_W'(1);
      end
      if (!br_en && !(&nt_q)) begin
        nt_q <= nt_q + STAT_W'(1);
      end
    end
  end

  assign br_taken_cnt = taken_q;
  assign br_nt_cnt    = nt_q;
`else
  assign br_taken_cnt = '0;
  assign br_nt_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed + randomized bench for pc_fetch_unit with a behavioural PC model.
module tb_pc_fetch_unit;
  import rv32i_types::*;

  localparam int unsigned TB_STAT_W = 2;
  localparam int unsigned STAT_MAX  = (1 << TB_STAT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  rv32i_word            mem_rdata;
  logic                 mem_resp;
  logic                 mem_read;
  rv32i_word            mem_address;
  rv32i_word            instr;
  logic                 instr_valid;
  logic                 upd_valid;
  pc_op_t               upd_op;
  logic                 br_en;
  rv32i_word            imm;
  rv32i_word            rs1_o;
  rv32i_word            pc;
  rv32i_word            pc_plus4;
  logic                 misalign;
  logic [TB_STAT_W-1:0] br_taken_cnt;
  logic [TB_STAT_W-1:0] br_nt_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] pc_m;
  bit          mis_m;
  int unsigned taken_m;
  int unsigned nt_m;

  pc_fetch_unit #(.RESET_PC(32'h0000_0060), .STAT_W(TB_STAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .upd_valid    (upd_valid),
    .upd_op       (upd_op),
    .br_en        (br_en),
    .imm          (imm),
    .rs1_o        (rs1_o),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign     (misalign),
    .br_taken_cnt (br_taken_cnt),
    .br_nt_cnt    (br_nt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_taken"}, 32'(br_taken_cnt), taken_m);
    check({tag, "_nt"}, 32'(br_nt_cnt), nt_m);
`else
    check({tag, "_taken"}, 32'(br_taken_cnt), 32'd0);
    check({tag, "_nt"}, 32'(br_nt_cnt), 32'd0);
`endif
  endtask

  // Currently in fetch: hold off the response for d cycles, then deliver word
  task automatic fetch(input logic [31:0] word, input int d);
    for (int i = 0; i < d; i++) begin
      check("fetch_wait_read", 32'(mem_read), 32'd1);
      check("fetch_wait_addr", mem_address, pc_m);
      tick();
    end
    mem_rdata = word;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = $urandom;
    check("issue_valid", 32'(instr_valid), 32'd1);
    check("issue_instr", instr, word);
    check("issue_noread", 32'(mem_read), 32'd0);
  endtask

  // Currently in issue: idle for w cycles, then request a PC update
  task automatic update(input pc_op_t op, input logic b, input logic [31:0] im,
                        input logic [31:0] r1, input int w);
    logic [31:0] tgt;
    for (int i = 0; i < w; i++) begin
      tick();
      check("issue_hold_valid", 32'(instr_valid), 32'd1);
      check("issue_hold_pc", pc, pc_m);
    end
    case (op)
      PC_SEQ:  tgt = pc_m + 32'd4;
      PC_BR:   tgt = b ? pc_m + im : pc_m + 32'd4;
      PC_JAL:  tgt = pc_m + im;
      default: tgt = (r1 + im) & ~32'd1;
    endcase
    if (tgt % 4 != 0) mis_m = 1'b1;
    pc_m = tgt - (tgt % 4);
    if (op == PC_BR) begin
      if (b && taken_m < STAT_MAX) taken_m++;
      if (!b && nt_m < STAT_MAX) nt_m++;
    end
    upd_op    = op;
    br_en     = b;
    imm       = im;
    rs1_o     = r1;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    check("upd_pc", pc, pc_m);
    check("upd_addr", mem_address, pc_m);
    check("upd_plus4", pc_plus4, pc_m + 32'd4);
    check("upd_misalign", 32'(misalign), 32'(mis_m));
    check("upd_read", 32'(mem_read), 32'd1);
    check("upd_novalid", 32'(instr_valid), 32'd0);
    check_counters("upd_cnt");
  endtask

  initial begin
    pc_op_t      rop;
    logic [31:0] rimm;
    rst       = 1'b1;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    upd_valid = 1'b0;
    upd_op    = PC_SEQ;
    br_en     = 1'b0;
    imm       = '0;
    rs1_o     = '0;
    pc_m      = 32'h60;
    mis_m     = 1'b0;
    taken_m   = 0;
    nt_m      = 0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h60);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check_counters("rst_cnt");
    rst = 1'b0;
    check("idle_read", 32'(mem_read), 32'd0);
    check("idle_pc", pc, 32'h60);
    tick();
    check("first_read", 32'(mem_read), 32'd1);
    check("first_addr", mem_address, 32'h60);

    // First fetch with a three-cycle memory latency
    fetch(32'h00A0_0093, 3);

    // Branch taken / not taken from 0x64 with imm=-8
    update(PC_SEQ, 1'b0, 32'd0, 32'd0, 0);
    fetch($urandom, 1);
    update(PC_BR, 1'b1, 32'hFFFF_FFF8, 32'd0, 1);
    check("br_taken_pc", pc, 32'h5C);
    fetch($urandom, 0);
    update(PC_SEQ, 1'b0, 32'd0, 32'd0, 0);
    fetch($urandom, 0);
    update(PC_SEQ, 1'b0, 32'd0, 32'd0, 0);
    fetch($urandom, 2);
    update(PC_BR, 1'b0, 32'hFFFF_FFF8, 32'd0, 0);
    check("br_nt_pc", pc, 32'h68);

    // Jump to the top word, then wrap with a sequential update
    fetch($urandom, 0);
    update(PC_JAL, 1'b0, 32'hFFFF_FFFC - 32'h68, 32'd0, 0);
    check("jal_top_pc", pc, 32'hFFFF_FFFC);
    fetch($urandom, 1);
    update(PC_SEQ, 1'b0, 32'd0, 32'd0, 0);
    check("wrap_pc", pc, 32'h0);

    // upd_valid during fetch must be ignored
    upd_op    = PC_JAL;
    imm       = 32'h100;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    check("fetch_upd_pc", pc, 32'h0);
    check("fetch_upd_read", 32'(mem_read), 32'd1);
    fetch($urandom, 0);

    // Misaligned JALR target; flag is sticky
    update(PC_JALR, 1'b0, 32'd4, 32'h1003, 0);
    check("jalr_mis_pc", pc, 32'h1004);
    check("jalr_mis_flag", 32'(misalign), 32'd1);
    fetch($urandom, 0);
    update(PC_SEQ, 1'b0, 32'd0, 32'd0, 0);
    check("mis_sticky", 32'(misalign), 32'd1);

    // Four taken branches drive the taken counter to saturation
    for (int i = 0; i < 4; i++) begin
      fetch($urandom, 0);
      update(PC_BR, 1'b1, 32'd8, 32'd0, 0);
    end

    // Randomized sequence against the reference model
    for (int i = 0; i < 40; i++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      rop  = pc_op_t'($urandom_range(0, 3));
      rimm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
      update(rop, 1'($urandom), rimm, $urandom, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a fetch
    check("pre_rst_read", 32'(mem_read), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    pc_m    = 32'h60;
    mis_m   = 1'b0;
    taken_m = 0;
    nt_m    = 0;
    check("midrst_read", 32'(mem_read), 32'd0);
    check("midrst_pc", pc, 32'h60);
    check("midrst_misalign", 32'(misalign), 32'd0);
    check("midrst_instr", instr, 32'd0);
    check_counters("midrst_cnt");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_read", 32'(mem_read), 32'd1);
    check("post_rst_addr", mem_address, 32'h60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
